keypad_scan_sequencer: RTL and testbench
========================================

# keypad_scan_sequencer

Sequencer for the 4x4 matrix keypad. It drives the active-low column scan with a programmable settle time and samples the active-low rows through a synchronizer. Every key is debounced across full sweeps. Outputs are debounced key levels plus one-cycle press/release events, which feed the fighter input mappers in place of raw per-clock scanning.

## Interface
- SETTLE_CYCLES, 1000: cycles a column is driven before its rows are sampled; minimum 3, which covers the 2-flop synchronizer.
- DEBOUNCE_SCANS, 4: consecutive full sweeps a key's raw value must differ from its debounced value before the change is accepted; range 1..15.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- scan_en  in  1  high: sweep continuously; low: finish the current sweep, then park.
- rows  in  4  keypad rows, active low (0 = pressed key on the driven column).
- cols  out  4  column drive, active low, one-cold while scanning.
- key_state  out  16  debounced level, 1 = held; index = row*4 + col.
- key_press  out  16  one-cycle pulse on an accepted 0->1 transition.
- key_release  out  16  one-cycle pulse on an accepted 1->0 transition.
- scan_done  out  1  one-cycle pulse per completed sweep.
- busy  out  1  high in any state other than IDLE.

## Operation
- rows pass through a 2-flop synchronizer; only synchronized values are sampled.
- FSM states: IDLE, DRIVE, SAMPLE, UPDATE.
- IDLE:
  - cols = 4'b1111.
  - Moves to DRIVE with col = 0 when scan_en = 1.
- DRIVE:
  - cols = ~(4'b0001 << col).
  - The settle counter runs 0..SETTLE_CYCLES-1; the last count moves to SAMPLE.
- SAMPLE, one cycle:
  - cols is held.
  - raw[row*4+col] <= ~rows_sync[row] for all 4 rows.
  - If col < 3: col increments and the FSM returns to DRIVE with the settle counter cleared.
  - If col = 3: the FSM moves to UPDATE.
- UPDATE, one cycle:
  - cols = 4'b1111.
  - Per-key debounce is applied, as below.
  - scan_done, key_press and key_release are registered at this edge, so they are high for exactly the following cycle.
  - Next state is DRIVE with col = 0 if scan_en = 1, else IDLE.
- Per-key debounce, one counter per key, width 4:
  - raw == key_state: the counter clears.
  - raw != key_state and counter+1 == DEBOUNCE_SCANS: key_state toggles, the counter clears, and the matching press or release bit pulses.
  - Otherwise the counter increments.
- scan_en is sampled only in IDLE and UPDATE; deasserting it mid-sweep never truncates a sweep.
- Several keys may change in the same UPDATE; all of their pulse bits assert together.
- A key that bounces back before reaching DEBOUNCE_SCANS produces no pulse and leaves key_state unchanged.

## Timing
- Column dwell is SETTLE_CYCLES+1 cycles; a sweep is T = 4*(SETTLE_CYCLES+1)+1 cycles.
- After rst deasserts with scan_en = 1, the FSM is IDLE for 1 cycle, then cols = 4'b1110 from the next cycle.
- The first scan_done occurs T+1 cycles after leaving IDLE.
- Press latency, from a stable press to the key_press pulse: at most (DEBOUNCE_SCANS+1)*T + 2 cycles and at least (DEBOUNCE_SCANS-1)*T + 1.
- Reset values, also applied on async rst at any time including mid-sweep:
  - cols = 4'b1111.
  - key_state, key_press, key_release, scan_done, busy = 0.
  - All counters = 0, col = 0, raw = 0, synchronizer = 4'b1111, state = IDLE.

## Test plan
All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_SCANS=2, giving T = 21.
- Idle scan: rows = 4'b1111, scan_en = 1 -> cols cycles 1110/1101/1011/0111 at 5 cycles each, then 1111 for 1 cycle; scan_done pulses every 21 cycles; key_state stays 0; no press or release pulses.
- Stable press: row 3 held low whenever col 1 is driven (key 13) -> exactly one key_press[13] pulse, at the second UPDATE after the press is first sampled; key_state[13] = 1 from that cycle on. Releasing it -> one key_release[13] pulse two sweeps later.
- Bounce: key 0 pressed for exactly one sweep, then released -> no key_press[0] pulse; key_state[0] stays 0.
- Simultaneous: keys 3, 7, 11, 15 pressed in the same cycle -> key_press = 16'h8888 for one cycle; key_state = 16'h8888.
- scan_en low asserted while col = 1 -> sweep completes, scan_done pulses once, then IDLE with cols = 1111 and busy = 0 until scan_en returns high.
- rst asserted mid-DRIVE while key_state = 16'h0001 -> all outputs at reset values immediately; after release, scanning restarts at col 0.

Source files
------------

// File: rtl/keypad_scan_sequencer.sv
// keypad_scan_sequencer -- 4x4 matrix keypad sweep, synchronizer and per-key debounce.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   scan_en         1: sweep continuously; 0: finish the current sweep, then park in IDLE
//   rows[3:0]       keypad rows, active low, synchronized internally
//   cols[3:0]       column drive, active low, one-cold while a column is driven
//   key_state[15:0] debounced levels, index = row*4 + col
//   key_press       one-cycle pulse on an accepted 0->1 change
//   key_release     one-cycle pulse on an accepted 1->0 change
//   scan_done       one-cycle pulse per completed sweep
//   busy            high whenever the sequencer is not IDLE

// One debounce slice per key. The update strobe marks the UPDATE cycle,
// when the freshly captured raw value for this key is complete.
module keypad_key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic update,
  input  logic raw,
  output logic state,
  output logic press,
  output logic rel
);
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      state <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (update) begin
        if (raw == state) begin
          cnt <= '0;
        end else if (cnt + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
          state <= ~state;
          cnt   <= '0;
          press <= raw;
          rel   <= ~raw;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end
endmodule

module keypad_scan_sequencer #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [15:0] key_state,
  output logic [15:0] key_press,
  output logic [15:0] key_release,
  output logic        scan_done,
  output logic        busy
);
  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, UPDATE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      col;
  logic [CW-1:0]   settle_cnt;
  logic [3:0]      rows_meta, rows_sync;
  logic [15:0]     raw;
  logic            settle_last;

  assign settle_last = (settle_cnt == CW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cols      = 4'b1111;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (scan_en) state_nxt = DRIVE;
      DRIVE: begin
        cols = ~(4'b0001 << col);
        if (settle_last) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        cols      = ~(4'b0001 << col);
        state_nxt = (col == 2'd3) ? UPDATE : DRIVE;
      end
      UPDATE:  state_nxt = scan_en ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: synchronizer, column/settle counters, raw capture, sweep pulse.
  // Reset idles the synchronizer at "no key" so nothing spurious is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_meta  <= 4'b1111;
      rows_sync  <= 4'b1111;
      col        <= '0;
      settle_cnt <= '0;
      raw        <= '0;
      scan_done  <= 1'b0;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          col        <= '0;
          settle_cnt <= '0;
        end
        DRIVE: settle_cnt <= settle_last ? '0 : settle_cnt + 1'b1;
        SAMPLE: begin
          for (int r = 0; r < 4; r++) raw[{2'(r), col}] <= ~rows_sync[r];
          if (col != 2'd3) col <= col + 2'd1;
          settle_cnt <= '0;
        end
        UPDATE: begin
          col        <= '0;
          settle_cnt <= '0;
          scan_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_key
    keypad_key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_dbc (
      .clk    (clk),
      .rst    (rst),
      .update (state == UPDATE),
      .raw    (raw[k]),
      .state  (key_state[k]),
      .press  (key_press[k]),
      .rel    (key_release[k])
    );
  end
endmodule

// File: tb/tb_keypad_scan_sequencer.sv
module tb_keypad_scan_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] key_state, key_press, key_release;
  logic        scan_done, busy;
  logic [15:0] pressed;

  int compared = 0;
  int failed   = 0;

  keypad_scan_sequencer #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .rows(rows), .cols(cols),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .scan_done(scan_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!cols[c] && pressed[r*4+c]) rows[r] = 1'b0;
  end

  typedef struct packed {
    logic [15:0] pressed;
    logic [15:0] st;
    logic [15:0] pr;
    logic [15:0] rl;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 60);
    if (!scan_done) begin
      compared++;
      failed++;
      $display("FAIL %s: scan_done timeout after %0d cycles", name, n);
    end
  endtask

  task automatic wait_cols(input string name, input logic [3:0] want);
    int n = 0;
    while (cols !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (cols !== want) begin
      compared++;
      failed++;
      $display("FAIL %s: cols %b never reached %b", name, cols, want);
    end
  endtask

  initial begin
    logic [3:0] exp_cols;
    int n, bad;

    // pressed, expected key_state, key_press, key_release at the sweep's scan_done
    vecs[0]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{16'h2000, 16'h0000, 16'h0000, 16'h0000};
    vecs[3]  = '{16'h2000, 16'h2000, 16'h2000, 16'h0000};
    vecs[4]  = '{16'h2000, 16'h2000, 16'h0000, 16'h0000};
    vecs[5]  = '{16'h0000, 16'h2000, 16'h0000, 16'h0000};
    vecs[6]  = '{16'h0000, 16'h0000, 16'h0000, 16'h2000};
    vecs[7]  = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    vecs[8]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[9]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[10] = '{16'h8888, 16'h0000, 16'h0000, 16'h0000};
    vecs[11] = '{16'h8888, 16'h8888, 16'h8888, 16'h0000};
    vecs[12] = '{16'h8888, 16'h8888, 16'h0000, 16'h0000};
    vecs[13] = '{16'h0088, 16'h8888, 16'h0000, 16'h0000};
    vecs[14] = '{16'h0088, 16'h0088, 16'h0000, 16'h8800};
    vecs[15] = '{16'h0089, 16'h0088, 16'h0000, 16'h0000};
    vecs[16] = '{16'h0089, 16'h0089, 16'h0001, 16'h0000};
    vecs[17] = '{16'h0001, 16'h0089, 16'h0000, 16'h0000};
    vecs[18] = '{16'h0001, 16'h0001, 16'h0000, 16'h0088};

    rst = 1'b1;
    scan_en = 1'b1;
    pressed = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cols", cols, 4'b1111);
    chk("rst_busy", busy, 0);
    chk("rst_state", key_state, 0);
    chk("rst_done", scan_done, 0);

    // First sweep, cycle by cycle: one IDLE cycle, 5 cycles per column, one UPDATE.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_cols", cols, 4'b1111);
    chk("idle_busy", busy, 0);
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      exp_cols = (k < 20) ? ~(4'b0001 << (k / 5)) : (k == 20) ? 4'b1111 : 4'b1110;
      chk($sformatf("sweep_cols_k%0d", k), cols, exp_cols);
      chk($sformatf("sweep_done_k%0d", k), scan_done, (k == 21));
    end
    chk("sweep_busy", busy, 1);
    chk("sweep_idle_state", key_state, 0);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 40);
    chk("sweep_period", n, 21);

    // Per-sweep table: pattern held for one sweep, results checked at its scan_done.
    for (int i = 0; i < 19; i++) begin
      pressed = vecs[i].pressed;
      wait_done($sformatf("vec%0d_wait", i));
      chk($sformatf("vec%0d_state", i), key_state, vecs[i].st);
      chk($sformatf("vec%0d_press", i), key_press, vecs[i].pr);
      chk($sformatf("vec%0d_release", i), key_release, vecs[i].rl);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_clr", i), {key_press, key_release, 15'd0, scan_done}, 0);
    end

    // scan_en dropped while column 1 is driven: sweep completes, then park.
    wait_cols("en_wait_col1", 4'b1101);
    scan_en = 1'b0;
    wait_done("en_finish");
    chk("en_park_cols", cols, 4'b1111);
    chk("en_park_busy", busy, 0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || scan_done || cols !== 4'b1111) bad++;
    end
    chk("en_parked", bad, 0);
    scan_en = 1'b1;
    @(negedge clk);
    chk("en_resume_cols", cols, 4'b1110);
    chk("en_resume_busy", busy, 1);

    // Async reset mid-DRIVE with key 0 held.
    chk("pre_rst_state", key_state, 16'h0001);
    wait_cols("rst_wait_col2", 4'b1011);
    #1 rst = 1'b1;
    #1;
    chk("arst_cols", cols, 4'b1111);
    chk("arst_busy", busy, 0);
    chk("arst_state", key_state, 0);
    chk("arst_pulses", {key_press, key_release, 15'd0, scan_done}, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_cols", cols, 4'b1111);
    @(negedge clk);
    chk("arst_restart_cols", cols, 4'b1110);
    wait_done("arst_sweep1");
    chk("arst_sweep1_state", key_state, 0);
    wait_done("arst_sweep2");
    chk("arst_sweep2_state", key_state, 16'h0001);
    chk("arst_sweep2_press", key_press, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
